// File: rtl/pipeline_control_if.sv
// Hazard inputs and stall/flush controls exchanged between the pipeline and its sequencer.
interface pipeline_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic             icache_miss;
    logic             dcache_miss;
    logic             load_use;
    logic             branch_taken;
    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             em_flush;
    logic             mw_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  icache_miss, dcache_miss, load_use, branch_taken,
        output pc_en, fd_en, de_en, em_en, mw_en,
        output fd_flush, de_flush, em_flush, mw_flush,
        output state, stall_cycles
    );

    modport slave (
        output icache_miss, dcache_miss, load_use, branch_taken,
        input  pc_en, fd_en, de_en, em_en, mw_en,
        input  fd_flush, de_flush, em_flush, mw_flush,
        input  state, stall_cycles
    );
endinterface

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the F/D/E/M/WB pipeline: per-cycle PC and stage
// register load/bubble control, cache-wait FSM and a saturating stall counter.
module pipeline_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_control_if.master ctl
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        IWAIT  = 2'd1,
        DWAIT  = 2'd2,
        IDRAIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             drain_pending_q, drain_pending_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_flush, de_flush, em_flush, mw_flush;

    always_comb begin
        pc_en           = 1'b1;
        fd_en           = 1'b1;
        de_en           = 1'b1;
        em_en           = 1'b1;
        mw_en           = 1'b1;
        fd_flush        = 1'b0;
        de_flush        = 1'b0;
        em_flush        = 1'b0;
        mw_flush        = 1'b0;
        state_d         = state_q;
        drain_pending_d = drain_pending_q;

        if (ctl.dcache_miss) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_flush = 1'b1;
            state_d  = DWAIT;
            if (ctl.branch_taken && ctl.icache_miss)
                drain_pending_d = 1'b1;
        end else begin
            if (state_q == IDRAIN) begin
                pc_en    = 1'b0;
                fd_flush = 1'b1;
                if (!ctl.icache_miss)
                    state_d = RUN;
            end else if (ctl.branch_taken) begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                state_d  = ctl.icache_miss ? IDRAIN : RUN;
            end else if (ctl.load_use) begin
                pc_en    = 1'b0;
                fd_en    = 1'b0;
                de_flush = 1'b1;
            end else if (ctl.icache_miss) begin
                pc_en    = 1'b0;
                fd_flush = 1'b1;
                state_d  = IWAIT;
            end else begin
                state_d = RUN;
            end

            // Leaving DWAIT: outputs use the normal rules, but the next state
            // comes from the drain recorded while M was stalled.
            if (state_q == DWAIT) begin
                if (drain_pending_q) begin
                    state_d         = IDRAIN;
                    drain_pending_d = 1'b0;
                end else if (ctl.icache_miss) begin
                    state_d = IWAIT;
                end else begin
                    state_d = RUN;
                end
            end
        end

        if (!reset) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b0;
            de_flush = 1'b0;
            em_flush = 1'b0;
            mw_flush = 1'b0;
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= RUN;
            drain_pending_q <= 1'b0;
            stall_cycles_q  <= '0;
        end else begin
            state_q         <= state_d;
            drain_pending_q <= drain_pending_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign ctl.pc_en        = pc_en;
    assign ctl.fd_en        = fd_en;
    assign ctl.de_en        = de_en;
    assign ctl.em_en        = em_en;
    assign ctl.mw_en        = mw_en;
    assign ctl.fd_flush     = fd_flush;
    assign ctl.de_flush     = de_flush;
    assign ctl.em_flush     = em_flush;
    assign ctl.mw_flush     = mw_flush;
    assign ctl.state        = state_q;
    assign ctl.stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the five-stage core pipeline (F, D, E, M, WB). Each cycle it decides whether the PC register and each inter-stage pipeline register (F/D, D/E, E/M, M/W) loads, holds, or loads a bubble. Inputs are the hazard and cache-miss signals. An internal FSM tracks multi-cycle instruction/data cache stalls and discards a stale fetch after a branch redirect. It also counts stall cycles for performance monitoring.

## Interface
- CNT_W, 32, width of the stall-cycle counter
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low; state cleared immediately when low
- icache_miss  in  1  fetch data not valid this cycle (level, held until data returns); icache holds returned data while PC is held
- dcache_miss  in  1  M-stage memory access not complete this cycle (level)
- load_use  in  1  instruction in D needs the result of a load currently in E
- branch_taken  in  1  E-stage control transfer taken; PC mux selects target
- pc_en  out  1  PC register load enable
- fd_en, de_en, em_en, mw_en  out  1 each  pipeline register load enables
- fd_flush, de_flush, em_flush, mw_flush  out  1 each  when set with matching _en, register loads a bubble (NOP, valid=0)
- state  out  2  FSM state: RUN=0, IWAIT=1, DWAIT=2, IDRAIN=3
- stall_cycles  out  CNT_W  number of cycles with pc_en=0, saturating

## Operation
- Outputs are combinational from state and inputs. While reset=0, every _en and _flush output is 0, state=RUN, and stall_cycles=0.
- Default (no event): all _en=1, all _flush=0.
- Priority, highest first: dcache_miss > branch_taken > load_use > icache_miss / IDRAIN.
- Any state with dcache_miss=1:
  - pc_en=fd_en=de_en=em_en=0; mw_en=1, mw_flush=1.
  - Next state is DWAIT.
  - If branch_taken && icache_miss, set drain_pending.
- DWAIT with dcache_miss=0:
  - Outputs follow the RUN rules below.
  - Next state is IDRAIN if drain_pending (then clear it), else IWAIT if icache_miss, else RUN.
- RUN/IWAIT, branch_taken=1:
  - pc_en=1 (redirect); fd_flush=de_flush=1; em/mw advance.
  - Next state is IDRAIN if icache_miss=1, else RUN.
  - The load_use in the same cycle is ignored (its instruction is squashed).
- RUN/IWAIT, load_use=1:
  - pc_en=0, fd_en=0; de_en=1, de_flush=1; em/mw advance.
  - State is unchanged.
- RUN, icache_miss=1: pc_en=0; fd_en=1, fd_flush=1; others advance; next state IWAIT.
- IWAIT:
  - icache_miss=1: same outputs as above, stay in IWAIT.
  - icache_miss=0: default outputs, back to RUN.
- IDRAIN (stale fetch in flight after redirect):
  - pc_en=0; fd_en=1, fd_flush=1; others advance.
  - When icache_miss=0, the returned stale instruction is bubbled in that same cycle and next state is RUN; fetch of the target starts the following cycle.
- stall_cycles increments on every clock edge where reset=1 and pc_en=0, and saturates at 2^CNT_W−1.

## Timing
- Zero-latency control: enables and flushes take effect at the same edge the hazard is presented.
- FSM transitions occur at posedge clk. Reset acts asynchronously on negedge of reset.
- Reset released mid-stall: the FSM restarts in RUN; the pipeline registers are assumed reset by their own reset.
- Simultaneous dcache_miss and branch_taken: the branch is frozen in E and re-presented after DWAIT; no redirect occurs during DWAIT.
- icache_miss falling in the same cycle as branch_taken: next state is RUN (no drain needed).

## Test plan
- Reset low with random inputs → all enables 0, state=0, stall_cycles=0; reset high, idle → all _en=1, all flush=0.
- load_use for 1 cycle → pc_en=0, fd_en=0, de_flush=1 for exactly that cycle; stall_cycles=1.
- icache_miss high for 3 cycles → state 1 for cycles 2–4, fd_flush=1 for 3 cycles, back to RUN on the 4th; stall_cycles=3.
- branch_taken with icache_miss=1, miss clears 2 cycles later → redirect cycle pc_en=1, state=3 for 2 cycles, fd_flush=1 for 2 cycles including the return cycle, then RUN.
- dcache_miss for 4 cycles with branch_taken and load_use high → mw_flush=1 and others frozen for 4 cycles, state=2; then the branch redirect wins with fd_flush=de_flush=1.
- CNT_W=4, pc_en held 0 for 20 cycles → stall_cycles saturates at 15.
